// File: rtl/oai21_pkg.sv
// Shared definitions for the OAI21 X4 cell: reset level, default counter width
// and the single-lane logic function used by RTL and reference models alike.
package oai21_pkg;

  localparam logic        ZN_RST    = 1'b1;
  localparam int unsigned CNT_W_DEF = 16;

  function automatic logic oai21_f(input logic a, input logic b1, input logic b2);
    return ~(a & (b1 | b2));
  endfunction

endpackage

// File: rtl/oai21_x4_cell_lane_cnt.sv
// Single-lane saturating transition counter; clears on rst, holds at all-ones.
module oai21_lane_cnt
  import oai21_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             toggle,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (toggle && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/oai21_x4_cell.sv
// Bit-parallel OAI21 (ZN = ~(A & (B1 | B2))) with per-lane ZN activity counters.
// Define OAI21_X4_CELL_REG_EN to make ZN_q a registered copy of ZN.
module oai21_x4_cell
  import oai21_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B1,
  input  logic [WIDTH-1:0]       B2,
  output logic [WIDTH-1:0]       ZN,
  output logic [WIDTH-1:0]       ZN_q,
  output logic [WIDTH*CNT_W-1:0] toggle_cnt
);

  logic [WIDTH-1:0] zn_prev;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    assign ZN[g] = oai21_f(A[g], B1[g], B2[g]);

    oai21_lane_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .toggle (ZN[g] ^ zn_prev[g]),
      .cnt    (toggle_cnt[g*CNT_W +: CNT_W])
    );
  end

  // Reset level matches ZN for all-zero inputs, so an idle lane counts nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      zn_prev <= {WIDTH{ZN_RST}};
    end else begin
      zn_prev <= ZN;
    end
  end

`ifdef OAI21_X4_CELL_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ZN_q <= {WIDTH{ZN_RST}};
    end else begin
      ZN_q <= ZN;
    end
  end
`else
  assign ZN_q = ZN;
`endif

endmodule

// File: tb/tb_oai21_x4_cell.sv
// Self-checking bench for oai21_x4_cell (WIDTH=4, CNT_W=3): truth-table model plus directed vectors.
module tb_oai21_x4_cell;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned CMAX = (1 << CW) - 1;
`ifdef OAI21_X4_CELL_REG_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  A, B1, B2;
  logic [W-1:0]  ZN, ZN_q;
  logic [W*CW-1:0] toggle_cnt;

  int errors = 0;
  int checks = 0;

  // Truth table indexed by {A,B1,B2}: 000..100 -> 1, 101..111 -> 0
  logic [7:0] tt = 8'b0001_1111;
  logic       exp_tt [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  oai21_x4_cell #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B1         (B1),
    .B2         (B2),
    .ZN         (ZN),
    .ZN_q       (ZN_q),
    .toggle_cnt (toggle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_zn(input logic [W-1:0] a, input logic [W-1:0] b1,
                                          input logic [W-1:0] b2);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = tt[{a[i], b1[i], b2[i]}];
    return r;
  endfunction

  // Reference model state
  bit           m_valid = 1'b0;
  int           m_cnt [W];
  logic [W-1:0] m_prev;
  logic [W-1:0] m_q;

  always @(posedge clk) begin
    logic [W-1:0] zc;
    zc = ref_zn(A, B1, B2);
    if (rst) begin
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
      m_prev  = '1;
      m_q     = '1;
      m_valid = 1'b1;
    end else begin
      for (int i = 0; i < W; i++)
        if (zc[i] != m_prev[i] && m_cnt[i] < CMAX) m_cnt[i]++;
      m_prev = zc;
      m_q    = zc;
    end
  end

  always @(negedge clk) begin
    logic [W-1:0]    zc;
    logic [W*CW-1:0] pk;
    if (m_valid) begin
      zc = ref_zn(A, B1, B2);
      for (int i = 0; i < W; i++) pk[i*CW +: CW] = CW'(m_cnt[i]);
      chk("model_zn", 32'(ZN), 32'(zc));
      chk("model_zn_q", 32'(ZN_q), REG ? 32'(m_q) : 32'(zc));
      chk("model_cnt", 32'(toggle_cnt), 32'(pk));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] kv;
    rst = 1'b1; A = '1; B1 = '1; B2 = '1;

    // Reset held with ZN=0 on all lanes
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_zn", 32'(ZN), 32'h0);
      chk("rst_zn_q", 32'(ZN_q), REG ? 32'hF : 32'h0);
      chk("rst_cnt", 32'(toggle_cnt), 32'h0);
    end
    rst = 1'b0;
    step();
    chk("release_cnt", 32'(toggle_cnt), 32'h249);
    chk("release_zn_q", 32'(ZN_q), 32'h0);

    // Four ZN transitions per lane after a fresh reset
    rst = 1'b1; A = '1; B1 = '0; B2 = '0;
    step();
    rst = 1'b0;
    B1 = '1; step();
    B1 = '0; step();
    B1 = '1; step();
    B1 = '0; step();
    chk("toggle4_cnt", 32'(toggle_cnt), 32'h924);

    // Saturation at 7 with ten more toggles
    for (int c = 0; c < 10; c++) begin
      B1 = ~B1;
      step();
    end
    chk("sat_cnt", 32'(toggle_cnt), 32'hFFF);
    B1 = ~B1; step();
    B1 = ~B1; step();
    chk("sat_hold_cnt", 32'(toggle_cnt), 32'hFFF);

    // Lane independence
    rst = 1'b1; A = '0; B1 = '0; B2 = '0;
    step();
    rst = 1'b0;
    A = 4'b1111; B1 = 4'b0101; B2 = 4'b0011;
    #1;
    chk("lanes_zn", 32'(ZN), 32'h8);
    step();
    chk("lanes_cnt", 32'(toggle_cnt), 32'h049);

    // Exhaustive sweep on lane 0
    A = '0; B1 = '0; B2 = '0;
    step();
    for (int k = 0; k < 8; k++) begin
      kv = 3'(k);
      A  = {3'b000, kv[2]};
      B1 = {3'b000, kv[1]};
      B2 = {3'b000, kv[0]};
      #1;
      chk("sweep_zn", 32'(ZN[0]), 32'(exp_tt[k]));
`ifndef OAI21_X4_CELL_REG_EN
      chk("sweep_zn_q_comb", 32'(ZN_q[0]), 32'(exp_tt[k]));
`endif
      step();
`ifdef OAI21_X4_CELL_REG_EN
      chk("sweep_zn_q_reg", 32'(ZN_q[0]), 32'(exp_tt[k]));
`endif
    end

    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
